// File: rtl/digit_shift_pkg.sv
// rtl/digit_shift_pkg.sv - opcodes and cell mux selects for the digit-entry shift register
package digit_shift_pkg;

  localparam int OP_W    = 3;
  localparam int BCD_MAX = 9;

  localparam logic [OP_W-1:0] OP_HOLD = 3'd0;
  localparam logic [OP_W-1:0] OP_PUSH = 3'd1;
  localparam logic [OP_W-1:0] OP_POP  = 3'd2;
  localparam logic [OP_W-1:0] OP_LOAD = 3'd3;
  localparam logic [OP_W-1:0] OP_CLR  = 3'd4;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_LOWER,
    SEL_UPPER,
    SEL_LOAD
  } cell_sel_e;

endpackage

// File: rtl/digit_cell.sv
// rtl/digit_cell.sv - one digit register with hold/shift-up/shift-down/load next-value mux
module digit_cell
  import digit_shift_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  cell_sel_e          sel,
  input  logic [DIGIT_W-1:0] from_lower,
  input  logic [DIGIT_W-1:0] from_upper,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] q
);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q <= '0;
    end else begin
      case (sel)
        SEL_LOWER: q <= from_lower;
        SEL_UPPER: q <= from_upper;
        SEL_LOAD:  q <= load_val;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/digit_shift_reg.sv
// rtl/digit_shift_reg.sv - keypad digit-entry shift register with backspace, load, clear and flags
module digit_shift_reg
  import digit_shift_pkg::*;
#(
  parameter int DIGIT_W  = 4,
  parameter int DEPTH    = 4,
  parameter int BCD      = 1,
  parameter int OVF_MODE = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       Ce,
  input  logic [OP_W-1:0]            Op,
  input  logic [DIGIT_W-1:0]         Din,
  input  logic [DIGIT_W*DEPTH-1:0]   Pin,
  output logic [DIGIT_W*DEPTH-1:0]   Dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  cell_sel_e     sel;
  logic          clr;
  logic          err_nxt;
  logic          din_bad;
  logic          pin_bad;
  logic [CW-1:0] count_nxt;

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

  always_comb begin
    din_bad = (BCD != 0) && (int'(Din) > BCD_MAX);
    pin_bad = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((BCD != 0) && (int'(Pin[k*DIGIT_W +: DIGIT_W]) > BCD_MAX)) pin_bad = 1'b1;
    end
  end

  // A rejected operation leaves every digit and the count untouched.
  always_comb begin
    sel       = SEL_HOLD;
    clr       = 1'b0;
    count_nxt = count;
    err_nxt   = 1'b0;
    if (Ce) begin
      case (Op)
        OP_HOLD: ;
        OP_PUSH: begin
          if (din_bad || (full && OVF_MODE == 0)) begin
            err_nxt = 1'b1;
          end else begin
            sel = SEL_LOWER;
            if (!full) count_nxt = count + CW'(1);
          end
        end
        OP_POP: begin
          if (empty) begin
            err_nxt = 1'b1;
          end else begin
            sel       = SEL_UPPER;
            count_nxt = count - CW'(1);
          end
        end
        OP_LOAD: begin
          if (pin_bad) begin
            err_nxt = 1'b1;
          end else begin
            sel       = SEL_LOAD;
            count_nxt = CNT_MAX;
          end
        end
        OP_CLR: begin
          sel       = SEL_LOAD;
          clr       = 1'b1;
          count_nxt = '0;
        end
        default: err_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      count <= count_nxt;
      err   <= err_nxt;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_cell
    logic [DIGIT_W-1:0] lower;
    logic [DIGIT_W-1:0] upper;
    logic [DIGIT_W-1:0] load_val;

    if (k == 0) begin : g_bot
      assign lower = Din;
    end else begin : g_mid_lo
      assign lower = Dout[(k-1)*DIGIT_W +: DIGIT_W];
    end

    if (k == DEPTH - 1) begin : g_top
      assign upper = '0;
    end else begin : g_mid_hi
      assign upper = Dout[(k+1)*DIGIT_W +: DIGIT_W];
    end

    assign load_val = clr ? '0 : Pin[k*DIGIT_W +: DIGIT_W];

    digit_cell #(.DIGIT_W(DIGIT_W)) u_cell (
      .CLK        (CLK),
      .RST        (RST),
      .sel        (sel),
      .from_lower (lower),
      .from_upper (upper),
      .load_val   (load_val),
      .q          (Dout[k*DIGIT_W +: DIGIT_W])
    );
  end

endmodule

// File: tb/tb_digit_shift_reg.sv
// tb/tb_digit_shift_reg.sv - directed self-checking bench for digit_shift_reg
module tb_digit_shift_reg;
  import digit_shift_pkg::*;

  logic        CLK;
  logic        RST;
  logic        Ce;
  logic [2:0]  Op;
  logic [3:0]  Din;
  logic [15:0] Pin;

  logic [15:0] dout_a, dout_o, dout_n;
  logic [2:0]  cnt_a, cnt_o, cnt_n;
  logic        full_a, full_o, full_n;
  logic        empty_a, empty_o, empty_n;
  logic        err_a, err_o, err_n;

  int tests = 0;
  int fails = 0;

  digit_shift_reg dut (
    .CLK(CLK), .RST(RST), .Ce(Ce), .Op(Op), .Din(Din), .Pin(Pin),
    .Dout(dout_a), .count(cnt_a), .full(full_a), .empty(empty_a), .err(err_a)
  );

  digit_shift_reg #(.OVF_MODE(1)) dut_ovf (
    .CLK(CLK), .RST(RST), .Ce(Ce), .Op(Op), .Din(Din), .Pin(Pin),
    .Dout(dout_o), .count(cnt_o), .full(full_o), .empty(empty_o), .err(err_o)
  );

  digit_shift_reg #(.BCD(0)) dut_nb (
    .CLK(CLK), .RST(RST), .Ce(Ce), .Op(Op), .Din(Din), .Pin(Pin),
    .Dout(dout_n), .count(cnt_n), .full(full_n), .empty(empty_n), .err(err_n)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ce, input logic [2:0] op, input logic [3:0] din,
                      input logic [15:0] pin);
    @(negedge CLK);
    Ce  = ce;
    Op  = op;
    Din = din;
    Pin = pin;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0;
    Ce  = 1'b0;
    Op  = OP_HOLD;
    Din = '0;
    Pin = '0;
    #12;
    chk("rst_dout", dout_a, 16'h0);
    chk("rst_count", cnt_a, 3'd0);
    chk("rst_empty", empty_a, 1'b1);
    chk("rst_full", full_a, 1'b0);
    chk("rst_err", err_a, 1'b0);
    @(negedge CLK);
    RST = 1'b1;

    step(1, OP_PUSH, 4'd1, 16'h0);
    chk("push1_err", err_a, 1'b0);
    step(1, OP_PUSH, 4'd2, 16'h0);
    chk("push2_err", err_a, 1'b0);
    step(1, OP_PUSH, 4'd3, 16'h0);
    chk("push3_err", err_a, 1'b0);
    chk("push3_dout", dout_a, 16'h0123);
    chk("push3_count", cnt_a, 3'd3);
    chk("push3_full", full_a, 1'b0);

    step(1, OP_PUSH, 4'd4, 16'h0);
    chk("push4_dout", dout_a, 16'h1234);
    chk("push4_full", full_a, 1'b1);
    step(1, OP_PUSH, 4'd5, 16'h0);
    chk("ovf0_dout", dout_a, 16'h1234);
    chk("ovf0_err", err_a, 1'b1);
    chk("ovf1_dout", dout_o, 16'h2345);
    chk("ovf1_count", cnt_o, 3'd4);
    chk("ovf1_err", err_o, 1'b0);
    step(1, OP_HOLD, 4'd0, 16'h0);
    chk("ovf0_err_drop", err_a, 1'b0);
    chk("hold_dout", dout_a, 16'h1234);

    step(1, OP_CLR, 4'd0, 16'h0);
    chk("clr_dout", dout_a, 16'h0);
    chk("clr_empty", empty_a, 1'b1);
    step(1, OP_PUSH, 4'd1, 16'h0);
    step(1, OP_PUSH, 4'd2, 16'h0);
    step(1, OP_PUSH, 4'd3, 16'h0);
    step(1, OP_POP, 4'd0, 16'h0);
    chk("pop1_dout", dout_a, 16'h0012);
    chk("pop1_count", cnt_a, 3'd2);
    step(1, OP_POP, 4'd0, 16'h0);
    chk("pop2_dout", dout_a, 16'h0001);
    step(1, OP_POP, 4'd0, 16'h0);
    chk("pop3_dout", dout_a, 16'h0);
    chk("pop3_empty", empty_a, 1'b1);
    chk("pop3_err", err_a, 1'b0);
    step(1, OP_POP, 4'd0, 16'h0);
    chk("pop4_err", err_a, 1'b1);
    chk("pop4_count", cnt_a, 3'd0);

    step(1, OP_PUSH, 4'hA, 16'h0);
    chk("bcd_dout", dout_a, 16'h0);
    chk("bcd_err", err_a, 1'b1);
    chk("nobcd_dout", dout_n, 16'h000A);
    chk("nobcd_count", cnt_n, 3'd1);
    chk("nobcd_err", err_n, 1'b0);

    step(0, OP_PUSH, 4'd7, 16'h0);
    chk("ce_low_dout", dout_n, 16'h000A);
    chk("ce_low_err", err_a, 1'b0);

    step(1, OP_LOAD, 4'd0, 16'h12A4);
    chk("load_bad_err", err_a, 1'b1);
    chk("load_bad_dout", dout_a, 16'h0);
    step(1, OP_LOAD, 4'd0, 16'h5959);
    chk("load_dout", dout_a, 16'h5959);
    chk("load_count", cnt_a, 3'd4);
    chk("load_full", full_a, 1'b1);
    chk("load_err", err_a, 1'b0);

    step(1, 3'd7, 4'd0, 16'h0);
    chk("op7_err", err_a, 1'b1);
    #2;
    RST = 1'b0;
    #1;
    chk("midrst_dout", dout_a, 16'h0);
    chk("midrst_count", cnt_a, 3'd0);
    chk("midrst_err", err_a, 1'b0);
    @(negedge CLK);
    RST = 1'b1;

    step(1, 3'd6, 4'd0, 16'h0);
    chk("op6_err", err_a, 1'b1);
    chk("op6_dout", dout_a, 16'h0);
    chk("op6_count", cnt_a, 3'd0);
    step(1, 3'd5, 4'd0, 16'h0);
    chk("op5_err_b2b", err_a, 1'b1);
    step(0, OP_HOLD, 4'd0, 16'h0);
    chk("err_clear", err_a, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
